// File: rtl/lane_serializer.sv
// lane_serializer: FIFO-buffered parallel-to-serial converter, LANES bits per beat, bit order chosen per word.
// Beat 0 registers one edge after the FIFO turns non-empty; words stream gaplessly; ready_o drops only on a full FIFO.
module lane_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [DATA_WIDTH-1:0]       parallel_in_i,
  input  logic                        lsb_first_i,
  input  logic                        valid_in_i,
  output logic                        ready_o,
  output logic [LANES-1:0]            serial_out_o,
  output logic                        enable_o,
  output logic                        start_o,
  output logic                        last_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);
  localparam int BEATS = DATA_WIDTH / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  lsb_q, lsb_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [LANES-1:0]      serial_q, serial_d;
  logic                  enable_q, enable_d;
  logic                  start_q, start_d;
  logic                  last_q, last_d;
  logic                  fifo_vld;
  logic                  fifo_pop;
  logic [DATA_WIDTH:0]   fifo_dat;

  lane_serializer_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .wr_vld_i (valid_in_i),
    .wr_dat_i ({lsb_first_i, parallel_in_i}),
    .wr_rdy_o (ready_o),
    .rd_vld_o (fifo_vld),
    .rd_dat_o (fifo_dat),
    .rd_pop_i (fifo_pop),
    .level_o  (fifo_level_o)
  );

  function automatic logic [LANES-1:0] beat_slice(input logic [DATA_WIDTH-1:0] w,
                                                  input logic                  lsb,
                                                  input logic [BW-1:0]         k);
    int base;
    base = int'(k) * LANES;
    if (lsb) return LANES'(w >> base);
    return LANES'(w >> (DATA_WIDTH - LANES - base));
  endfunction

  // Beat outputs are computed from next-state so they register alongside the load.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    lsb_d    = lsb_q;
    beat_d   = beat_q;
    fifo_pop = 1'b0;
    serial_d = '0;
    enable_d = 1'b0;
    start_d  = 1'b0;
    last_d   = 1'b0;

    case (state_q)
      IDLE: begin
        fifo_pop = fifo_vld;
      end
      SHIFT: begin
        if (beat_q == LAST_BEAT) begin
          fifo_pop = fifo_vld;
          if (!fifo_vld) state_d = IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fifo_pop) begin
      word_d  = fifo_dat[DATA_WIDTH-1:0];
      lsb_d   = fifo_dat[DATA_WIDTH];
      beat_d  = '0;
      state_d = SHIFT;
    end

    if (state_d == SHIFT) begin
      serial_d = beat_slice(word_d, lsb_d, beat_d);
      enable_d = 1'b1;
      start_d  = (beat_d == '0);
      last_d   = (beat_d == LAST_BEAT);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      word_q   <= '0;
      lsb_q    <= 1'b0;
      beat_q   <= '0;
      serial_q <= '0;
      enable_q <= 1'b0;
      start_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      lsb_q    <= lsb_d;
      beat_q   <= beat_d;
      serial_q <= serial_d;
      enable_q <= enable_d;
      start_q  <= start_d;
      last_q   <= last_d;
    end
  end

  assign serial_out_o = serial_q;
  assign enable_o     = enable_q;
  assign start_o      = start_q;
  assign last_o       = last_q;
endmodule

// lane_serializer_fifo: DEPTH-entry circular buffer with occupancy count; head data valid while rd_vld_o.
// Zero-latency read of the head; wr_rdy_o is low whenever full, even if a pop happens in the same cycle.
module lane_serializer_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   wr_vld_i,
  input  logic [WIDTH-1:0]       wr_dat_i,
  output logic                   wr_rdy_o,
  output logic                   rd_vld_o,
  output logic [WIDTH-1:0]       rd_dat_o,
  input  logic                   rd_pop_i,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             push, pop;

  assign wr_rdy_o = (level_q < FULL);
  assign rd_vld_o = (level_q != '0);
  assign push     = wr_vld_i && wr_rdy_o;
  assign pop      = rd_pop_i && rd_vld_o;
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign level_o  = level_q;
  assign level_d  = level_q + LW'(push) - LW'(pop);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat_i;
  end
endmodule

// File: tb/tb_lane_serializer.sv
// Bench for lane_serializer: three instances (1, 4 and 8 lanes) checked every cycle against a word-schedule model.
module tb_lane_serializer;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] din    [ND];
  logic       lsb_in [ND];
  logic       vld    [ND];
  logic       rdy    [ND];
  logic       en     [ND];
  logic       st     [ND];
  logic       la     [ND];
  logic [7:0] ser    [ND];
  logic [3:0] lvl    [ND];
  logic       ser0;
  logic [3:0] ser1;
  logic [7:0] ser2;
  logic [1:0] lvl0;
  logic [2:0] lvl1;
  logic [1:0] lvl2;

  assign ser[0] = {7'b0, ser0};
  assign ser[1] = {4'b0, ser1};
  assign ser[2] = ser2;
  assign lvl[0] = {2'b0, lvl0};
  assign lvl[1] = {1'b0, lvl1};
  assign lvl[2] = {2'b0, lvl2};

  lane_serializer #(.DATA_WIDTH(8), .LANES(1), .FIFO_DEPTH(2)) u_l1 (
    .clk_i(clk), .rst_n_i(rst_n), .parallel_in_i(din[0]), .lsb_first_i(lsb_in[0]),
    .valid_in_i(vld[0]), .ready_o(rdy[0]), .serial_out_o(ser0), .enable_o(en[0]),
    .start_o(st[0]), .last_o(la[0]), .fifo_level_o(lvl0));

  lane_serializer #(.DATA_WIDTH(8), .LANES(4), .FIFO_DEPTH(4)) u_l4 (
    .clk_i(clk), .rst_n_i(rst_n), .parallel_in_i(din[1]), .lsb_first_i(lsb_in[1]),
    .valid_in_i(vld[1]), .ready_o(rdy[1]), .serial_out_o(ser1), .enable_o(en[1]),
    .start_o(st[1]), .last_o(la[1]), .fifo_level_o(lvl1));

  lane_serializer #(.DATA_WIDTH(8), .LANES(8), .FIFO_DEPTH(2)) u_l8 (
    .clk_i(clk), .rst_n_i(rst_n), .parallel_in_i(din[2]), .lsb_first_i(lsb_in[2]),
    .valid_in_i(vld[2]), .ready_o(rdy[2]), .serial_out_o(ser2), .enable_o(en[2]),
    .start_o(st[2]), .last_o(la[2]), .fifo_level_o(lvl2));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lanes_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 4 : 8;
  endfunction

  function automatic int depth_of(input int d);
    return (d == 1) ? 4 : 2;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d edge=%0d: got 0x%0h, expected 0x%0h", name, d, cyc, act, exp);
    end
  endtask

  // Reference model: each accepted word gets a start edge S = max(accept+1, previous S + BEATS).
  typedef struct {
    int         d;
    logic [7:0] w;
    logic       lsb;
    int         n;
    int         s;
  } wrec_t;

  wrec_t mq [$];
  int    next_free [ND];

  function automatic logic [7:0] beat_bits(input logic [7:0] w, input logic lsb, input int L, input int k);
    logic [7:0] mask;
    mask = 8'((1 << L) - 1);
    if (lsb) return (w >> (k * L)) & mask;
    return (w >> (8 - (k + 1) * L)) & mask;
  endfunction

  task automatic model_step(input int d);
    int         L, B, lv, k;
    bit         act;
    wrec_t      cur, r;
    logic [7:0] eb;
    L = lanes_of(d);
    B = 8 / L;
    lv = 0; k = 0; act = 1'b0; eb = 8'h00;
    cur.d = 0; cur.w = 8'h00; cur.lsb = 1'b0; cur.n = 0; cur.s = 0;
    if (!rst_n) begin
      for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].d == d) mq.delete(i);
      next_free[d] = 0;
      chk("rst_ser", d, ser[d], 0);
      chk("rst_enable", d, en[d], 0);
      chk("rst_start", d, st[d], 0);
      chk("rst_last", d, la[d], 0);
      chk("rst_level", d, lvl[d], 0);
      chk("rst_ready", d, rdy[d], 1);
      return;
    end
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].d == d && mq[i].s + B - 1 < cyc) mq.delete(i);
    foreach (mq[i]) begin
      if (mq[i].d == d) begin
        if (mq[i].s <= cyc) begin
          act = 1'b1;
          cur = mq[i];
        end else begin
          lv++;
        end
      end
    end
    if (act) begin
      k  = cyc - cur.s;
      eb = beat_bits(cur.w, cur.lsb, L, k);
    end
    chk("ser", d, ser[d], eb);
    chk("enable", d, en[d], act);
    chk("start", d, st[d], act && k == 0);
    chk("last", d, la[d], act && k == B - 1);
    chk("level", d, lvl[d], lv);
    chk("ready", d, rdy[d], lv < depth_of(d));
    if (vld[d] && rdy[d]) begin
      r.d   = d;
      r.w   = din[d];
      r.lsb = lsb_in[d];
      r.n   = cyc + 1;
      r.s   = (r.n + 1 > next_free[d]) ? r.n + 1 : next_free[d];
      next_free[d] = r.s + B;
      mq.push_back(r);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) model_step(d);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int d, input logic [7:0] w, input logic l, output int acc);
    int budget;
    budget = 0;
    acc = -1;
    din[d] = w; lsb_in[d] = l; vld[d] = 1'b1;
    while (acc < 0 && budget < 64) begin
      @(negedge clk);
      if (rdy[d]) begin
        tick();
        acc = cyc;
      end else begin
        tick();
      end
      budget++;
    end
    vld[d] = 1'b0;
    chk("accept_timeout", d, acc >= 0, 1);
  endtask

  task automatic drive_words(input int d, input int n, input logic [7:0] ws [4]);
    int i, budget;
    i = 0; budget = 0;
    lsb_in[d] = 1'b0; din[d] = ws[0]; vld[d] = 1'b1;
    while (i < n && budget < 100) begin
      @(negedge clk);
      if (rdy[d]) begin
        tick();
        i++;
        if (i < n) din[d] = ws[i];
      end else begin
        tick();
      end
      budget++;
    end
    vld[d] = 1'b0;
    chk("drive_accepts", d, i, n);
  endtask

  typedef struct {
    int          d;
    logic [7:0]  w;
    logic        lsb;
    int          nb;
    logic [63:0] exp;
  } vec_t;

  localparam int NV = 7;
  vec_t tbl [NV];

  initial begin
    int         a, b, waitc, p, full_cycles;
    logic [31:0] acc;
    logic [7:0] ws [4];

    tbl[0] = '{0, 8'hC1, 1'b0, 8, 64'h0100_0000_0000_0101};
    tbl[1] = '{0, 8'hC1, 1'b1, 8, 64'h0101_0000_0000_0001};
    tbl[2] = '{1, 8'hC1, 1'b0, 2, 64'h0000_0000_0000_010C};
    tbl[3] = '{1, 8'hC1, 1'b1, 2, 64'h0000_0000_0000_0C01};
    tbl[4] = '{1, 8'h3C, 1'b0, 2, 64'h0000_0000_0000_0C03};
    tbl[5] = '{2, 8'hAA, 1'b0, 1, 64'h0000_0000_0000_00AA};
    tbl[6] = '{2, 8'h80, 1'b1, 1, 64'h0000_0000_0000_0080};

    for (int d = 0; d < ND; d++) begin
      din[d] = 8'h00; lsb_in[d] = 1'b0; vld[d] = 1'b0; next_free[d] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single words: exact beats, strobes and two-edge latency.
    for (int i = 0; i < NV; i++) begin
      repeat (12) tick();
      push_word(tbl[i].d, tbl[i].w, tbl[i].lsb, a);
      @(negedge clk);
      chk("tbl_early", tbl[i].d, en[tbl[i].d], 0);
      for (int k = 0; k < tbl[i].nb; k++) begin
        @(negedge clk);
        chk($sformatf("tbl%0d_ser%0d", i, k), tbl[i].d, ser[tbl[i].d], tbl[i].exp[k*8 +: 8]);
        chk($sformatf("tbl%0d_en%0d", i, k), tbl[i].d, en[tbl[i].d], 1);
        chk($sformatf("tbl%0d_st%0d", i, k), tbl[i].d, st[tbl[i].d], k == 0);
        chk($sformatf("tbl%0d_la%0d", i, k), tbl[i].d, la[tbl[i].d], k == tbl[i].nb - 1);
      end
      @(negedge clk);
      chk("tbl_after", tbl[i].d, en[tbl[i].d], 0);
    end

    // Four words held valid on the 1-lane, depth-2 instance.
    repeat (12) tick();
    ws[0] = 8'h01; ws[1] = 8'h02; ws[2] = 8'h03; ws[3] = 8'h04;
    fork
      drive_words(0, 4, ws);
      begin
        waitc = 0; acc = 32'h0; full_cycles = 0;
        while (!en[0] && waitc < 20) begin @(negedge clk); waitc++; end
        chk("stream_begin", 0, en[0], 1);
        for (int c = 0; c < 32; c++) begin
          if (c > 0) @(negedge clk);
          chk("stream_en", 0, en[0], 1);
          chk("stream_start", 0, st[0], (c % 8) == 0);
          acc = {acc[30:0], ser[0][0]};
          if (lvl[0] == 4'd2) begin
            full_cycles++;
            chk("stream_full_rdy", 0, rdy[0], 0);
          end
        end
        @(negedge clk);
        chk("stream_end", 0, en[0], 0);
        chk("stream_data", 0, acc, 32'h01020304);
        chk("stream_full_seen", 0, full_cycles > 0, 1);
      end
    join

    // Back-to-back full-width words: one beat each, start and last together.
    repeat (12) tick();
    ws[0] = 8'hAA; ws[1] = 8'h55; ws[2] = 8'hFF; ws[3] = 8'h00;
    fork
      drive_words(2, 3, ws);
      begin
        waitc = 0;
        while (!en[2] && waitc < 20) begin @(negedge clk); waitc++; end
        for (int c = 0; c < 3; c++) begin
          if (c > 0) @(negedge clk);
          chk("b2b_ser", 2, ser[2], ws[c]);
          chk("b2b_en", 2, en[2], 1);
          chk("b2b_st", 2, st[2], 1);
          chk("b2b_la", 2, la[2], 1);
        end
        @(negedge clk);
        chk("b2b_end", 2, en[2], 0);
      end
    join

    // Reset on beat 3 of 0xC1 with a second word queued.
    repeat (12) tick();
    push_word(0, 8'hC1, 1'b0, a);
    push_word(0, 8'h3C, 1'b0, b);
    chk("rst_second_accept", 0, b, a + 1);
    while (cyc < a + 4) tick();
    chk("rst_pre_beat", 0, en[0], 1);
    chk("rst_pre_level", 0, lvl[0], 1);
    rst_n = 1'b0;
    #1;
    chk("rst_now_ser", 0, ser[0], 0);
    chk("rst_now_en", 0, en[0], 0);
    chk("rst_now_st", 0, st[0], 0);
    chk("rst_now_la", 0, la[0], 0);
    chk("rst_now_level", 0, lvl[0], 0);
    chk("rst_now_ready", 0, rdy[0], 1);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("rst_residual", 0, en[0], 0);
    end
    tick();
    push_word(0, 8'h80, 1'b0, a);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_rst_ser", 0, ser[0], k == 0);
      chk("post_rst_en", 0, en[0], 1);
    end

    // Random traffic on all instances, alternating light and heavy load, with one reset.
    repeat (12) tick();
    for (int c = 0; c < 3000; c++) begin
      p = (((c / 250) % 2) != 0) ? 90 : 30;
      for (int d = 0; d < ND; d++) begin
        vld[d]    = ($urandom_range(0, 99) < p);
        din[d]    = 8'($urandom);
        lsb_in[d] = 1'($urandom);
      end
      if (c == 1700) rst_n = 1'b0;
      if (c == 1703) rst_n = 1'b1;
      tick();
    end
    for (int d = 0; d < ND; d++) vld[d] = 1'b0;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
